// File: rtl/serial_adder_2b.sv
// -----------------------------------------------------------------------------
// serial_adder_2b
// Sequential adder that adds two WIDTH-bit operands two bits per clock.
// Each RUN cycle pushes one 2-bit slice plus the running carry through a
// 2-bit add. The slice result goes into the sum register and the carry is
// chained to the next slice.
//
// Parameters:
//   WIDTH      operand/result width in bits (even, >= 2)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request, only accepted in IDLE or DONE
//   sub        (SERIAL_ADD_SUB_EN only) 1 = compute a - b
//   a, b       operands, captured on an accepted start
//   busy       high while slices are being processed
//   done       one-cycle pulse, sum/carry_out valid
//   sum        registered result
//   carry_out  carry out of the MSB slice (no-borrow flag when subtracting)
//
// Optional feature macro: SERIAL_ADD_SUB_EN adds the `sub` input.
// -----------------------------------------------------------------------------
module serial_adder_2b #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int STEPS = WIDTH / 2;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            accept_s;
    logic [1:0]      a_sl_s;
    logic [1:0]      b_sl_s;
    logic [2:0]      slice_s;

    // 2-bit add with carry-in; result is {carry, s[1:0]}
    function automatic logic [2:0] add2(input logic [1:0] x,
                                        input logic [1:0] y,
                                        input logic       ci);
        return {1'b0, x} + {1'b0, y} + {2'b00, ci};
    endfunction

    assign accept_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Select the operand slice addressed by the slice counter
    always_comb begin
        a_sl_s = 2'b00;
        b_sl_s = 2'b00;
        for (int i = 0; i < STEPS; i++) begin
            if (cnt_q == i[CW-1:0]) begin
                a_sl_s = a_q[2*i +: 2];
                b_sl_s = b_q[2*i +: 2];
            end else begin
                a_sl_s = a_sl_s;
                b_sl_s = b_sl_s;
            end
        end
        slice_s = add2(a_sl_s, b_sl_s, carry_q);
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    a_d     = a;
`ifdef SERIAL_ADD_SUB_EN
                    // Subtraction as a + ~b + 1: invert b here, seed carry with 1
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
`else
                    b_d     = b;
                    carry_d = 1'b0;
`endif
                    cnt_d   = {CW{1'b0}};
                    sum_d   = {WIDTH{1'b0}};
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                for (int i = 0; i < STEPS; i++) begin
                    if (cnt_q == i[CW-1:0]) begin
                        sum_d[2*i +: 2] = slice_s[1:0];
                    end else begin
                        sum_d[2*i +: 2] = sum_q[2*i +: 2];
                    end
                end
                carry_d = slice_s[2];
                if (cnt_q == LAST_SLICE) begin
                    cout_d  = slice_s[2];
                    cnt_d   = {CW{1'b0}};
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule
